// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX sequencer.
// The GAP state exists only when UART_TX_GAP_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_CTS  = 3'd1,
    LAUNCH    = 3'd2,
    WAIT_DONE = 3'd3
`ifdef UART_TX_GAP_EN
    ,
    GAP       = 3'd4
`endif
  } tx_sched_state_t;

  typedef logic [1:0] data_bits_t;

  localparam data_bits_t DB5 = 2'b00;
  localparam data_bits_t DB6 = 2'b01;
  localparam data_bits_t DB7 = 2'b10;
  localparam data_bits_t DB8 = 2'b11;

  // Frame configuration captured at launch and held for the whole frame.
  typedef struct packed {
    data_bits_t data_bits;
    logic       parity_en;
    logic       parity_type;
    logic       stop_bits;
  } tx_cfg_t;

  function automatic logic [7:0] data_mask(input data_bits_t db);
    logic [7:0] m;
    m = 8'hFF;
    case (db)
      DB5:     m = 8'h1F;
      DB6:     m = 8'h3F;
      DB7:     m = 8'h7F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Link between the TX sequencer (master) and uart_tx (slave):
// frame data, latched frame config, launch strobe and completion flag.
interface uart_tx_sched_if;
  import uart_pkg::*;

  logic [31:0] tx_data;
  data_bits_t  data_bit_num;
  logic        parity_en;
  logic        parity_type;
  logic        stop_bit_num;
  logic        start_tx;
  logic        tx_done;

  modport master (
    output tx_data,
    output data_bit_num,
    output parity_en,
    output parity_type,
    output stop_bit_num,
    output start_tx,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  data_bit_num,
    input  parity_en,
    input  parity_type,
    input  stop_bit_num,
    input  start_tx,
    output tx_done
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO; rdata shows the head while not empty.
// A push while full is accepted only if a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (AW+1)'(DEPTH));
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Byte FIFO plus launch sequencer feeding uart_tx, one frame per byte, gated by tx_en_i and cts_n.
// Optional inter-frame idle gap counted in tx_tick periods when UART_TX_GAP_EN is defined.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int GAP_TICKS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tx_tick,
  input  logic                       wr_en_i,
  input  logic [7:0]                 wr_data_i,
  input  logic                       tx_en_i,
  input  logic [1:0]                 cfg_data_bit_num_i,
  input  logic                       cfg_parity_en_i,
  input  logic                       cfg_parity_type_i,
  input  logic                       cfg_stop_bit_num_i,
  input  logic                       cts_n,
  uart_tx_sched_if.master            tx_if,
  output logic                       fifo_full_o,
  output logic                       fifo_empty_o,
  output logic [$clog2(DEPTH):0]     fifo_level_o,
  output logic                       overflow_o,
  output logic                       busy_o,
  output logic                       tx_empty_irq_o
);

  localparam int LW = $clog2(DEPTH) + 1;

  tx_sched_state_t state_q, state_d;
  logic [31:0]     tx_data_q, tx_data_d;
  tx_cfg_t         cfg_q, cfg_d;
  logic            done_prev_q;
  logic            overflow_q;
  logic            done_rise;

  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [7:0]      fifo_rdata;
  logic [LW-1:0]   fifo_level;

`ifdef UART_TX_GAP_EN
  localparam logic [7:0] GAP_LAST = 8'(GAP_TICKS - 1);
  logic [7:0] gap_cnt_q, gap_cnt_d;
`else
  logic gap_unused;
  assign gap_unused = tx_tick ^ (^8'(GAP_TICKS));
`endif

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en_i),
    .pop   (fifo_pop),
    .wdata (wr_data_i),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // A level-high tx_done must only end one frame.
  assign done_rise = tx_if.tx_done && !done_prev_q;

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    cfg_d     = cfg_q;
    fifo_pop  = 1'b0;
`ifdef UART_TX_GAP_EN
    gap_cnt_d = gap_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (tx_en_i && !fifo_empty) begin
          state_d = cts_n ? WAIT_CTS : LAUNCH;
        end
      end
      WAIT_CTS: begin
        if (!tx_en_i) begin
          state_d = IDLE;
        end else if (!cts_n) begin
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_rise) begin
`ifdef UART_TX_GAP_EN
          if (GAP_TICKS == 0) begin
            state_d = IDLE;
          end else begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef UART_TX_GAP_EN
      GAP: begin
        if (tx_tick) begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d = IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + 8'd1;
          end
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    // Capture head and config on the edge entering LAUNCH so they are valid with start_tx.
    if (state_d == LAUNCH) begin
      fifo_pop  = 1'b1;
      tx_data_d = {24'h0, fifo_rdata & data_mask(cfg_data_bit_num_i)};
      cfg_d     = '{data_bits:   cfg_data_bit_num_i,
                    parity_en:   cfg_parity_en_i,
                    parity_type: cfg_parity_type_i,
                    stop_bits:   cfg_stop_bit_num_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tx_data_q   <= '0;
      cfg_q       <= '0;
      done_prev_q <= 1'b0;
      overflow_q  <= 1'b0;
`ifdef UART_TX_GAP_EN
      gap_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      cfg_q       <= cfg_d;
      done_prev_q <= tx_if.tx_done;
      overflow_q  <= wr_en_i && fifo_full && !fifo_pop;
`ifdef UART_TX_GAP_EN
      gap_cnt_q   <= gap_cnt_d;
`endif
    end
  end

  assign tx_if.tx_data      = tx_data_q;
  assign tx_if.data_bit_num = cfg_q.data_bits;
  assign tx_if.parity_en    = cfg_q.parity_en;
  assign tx_if.parity_type  = cfg_q.parity_type;
  assign tx_if.stop_bit_num = cfg_q.stop_bits;
  assign tx_if.start_tx     = (state_q == LAUNCH);

  assign fifo_full_o    = fifo_full;
  assign fifo_empty_o   = fifo_empty;
  assign fifo_level_o   = fifo_level;
  assign overflow_o     = overflow_q;
  assign busy_o         = (state_q != IDLE);
  assign tx_empty_irq_o = fifo_empty && (state_q == IDLE);

endmodule
